wash_cycle_ctrl: RTL
====================

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the phase counter and of `remaining`.
REQ-002 Parameter T_FILL, default 1000000, FILL phase length in clk cycles.
REQ-003 Parameter T_WASH, default 1000000, WASH phase length in clk cycles.
REQ-004 Parameter T_RINSE, default 1000000, length of one RINSE pass in clk cycles.
REQ-005 Parameter T_SPIN, default 1000000, SPIN phase length in clk cycles.
REQ-006 Parameter N_RINSE, default 2, rinse passes in normal mode; legal range 1..7.
REQ-007 Ports, one per line:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; begins a cycle when sampled high in IDLE.
- mode  input  2  00 normal, 01 quick, 10 heavy, 11 treated as normal.
- pause  input  1  level; freezes the running phase.
- door_open  input  1  level; freezes like pause, and blocks start.
- state  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
- busy  output  1  high in FILL, WASH, RINSE and SPIN.
- held  output  1  high when busy and (pause or door_open).
- done  output  1  one-cycle pulse, high only in DONE.
- remaining  output  CNT_W  cycles left in the current phase minus 1.
- rinse_idx  output  3  current rinse pass, 0-based.

Function
REQ-008 Phase order SHALL be IDLE -> FILL -> WASH -> RINSE (repeated) -> SPIN -> DONE -> IDLE.
REQ-009 In IDLE, start=1 and door_open=0 SHALL latch mode and enter FILL on the next cycle; otherwise the block stays in IDLE.
REQ-010 start SHALL be ignored in every state except IDLE.
REQ-011 On entry to a phase, remaining SHALL load (phase length - 1); a phase length of 0 SHALL be treated as 1.
REQ-012 Each cycle with busy=1 and held=0, remaining SHALL decrement by 1.
REQ-013 When remaining=0 and held=0, the block SHALL advance to the next phase on the next edge, so an unheld phase lasts exactly its length.
REQ-014 When held=1, state, remaining and rinse_idx SHALL hold their values; the phase SHALL resume on the first cycle after held falls.
REQ-015 If held=1 in the same cycle that remaining=0, no advance SHALL occur.
REQ-016 Quick mode SHALL use a WASH length of T_WASH>>1, with a minimum of 1, and exactly 1 rinse pass.
REQ-017 Heavy mode SHALL use N_RINSE+1 rinse passes, with a maximum of 7.
REQ-018 Normal mode SHALL use T_WASH and N_RINSE passes.
REQ-019 rinse_idx SHALL be 0 on RINSE entry from WASH.
- It SHALL increment on each RINSE -> RINSE pass boundary.
- RINSE SHALL exit to SPIN when the last pass completes.
REQ-020 A mode change during a cycle SHALL have no effect until the next start.
REQ-021 DONE SHALL last exactly 1 cycle, then return to IDLE.
- start=1 during DONE SHALL be ignored.
- A restart requires start to be sampled in IDLE.
REQ-022 In IDLE and DONE, remaining and rinse_idx SHALL be 0.
REQ-023 Sizing of remaining to CNT_W:
- Phase lengths SHALL be truncated to CNT_W bits.
- remaining SHALL never wrap below 0.

Reset
REQ-024 With rst=1 at a clock edge, the next state SHALL be IDLE, with busy=0, held=0, done=0, remaining=0, rinse_idx=0 and the latched mode cleared to 00.
REQ-025 Reset SHALL take priority over start, pause and door_open.
REQ-026 Reset mid-phase SHALL abort the cycle with no done pulse.

Verification
Bench parameters: T_FILL=4, T_WASH=6, T_RINSE=3, T_SPIN=5, N_RINSE=2.
REQ-027 Normal run: start=1 for 1 cycle at t0 with mode=00.
- Required: FILL for 4 cycles, WASH 6, RINSE 6 (rinse_idx 0,0,0,1,1,1), SPIN 5.
- Required: done=1 exactly 22 cycles after t0, then IDLE.
REQ-028 Quick mode (mode=01): required WASH=3 cycles and a single RINSE of 3 cycles; done 16 cycles after start.
REQ-029 Heavy mode (mode=10): required 3 rinse passes (rinse_idx reaches 2); done 25 cycles after start.
REQ-030 Pause: pause=1 for 7 cycles in WASH at remaining=2.
- Required: state=WASH, remaining=2 and held=1 throughout.
- Required: completion exactly 7 cycles later than the normal run.
REQ-031 Blocking and restart:
- door_open=1 together with start=1 in IDLE -> required: stays in IDLE.
- start=1 asserted during SPIN -> required: ignored, and no second cycle begins.
REQ-032 Reset mid-RINSE: rst=1 for 1 cycle with rinse_idx=1.
- Required: next cycle state=0, remaining=0, rinse_idx=0.
- Required: no done pulse is ever produced for the aborted cycle.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer.
// Runs IDLE -> FILL -> WASH -> RINSE (one or more passes) -> SPIN -> DONE -> IDLE.
// Each phase is timed by a down-counter that freezes while the machine is held
// by pause or an open door. The wash mode is captured at start and governs the
// WASH length and the rinse pass count for the rest of the cycle.
module wash_cycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int T_FILL  = 1000000,
    parameter int T_WASH  = 1000000,
    parameter int T_RINSE = 1000000,
    parameter int T_SPIN  = 1000000,
    parameter int N_RINSE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             pause,
    input  logic             door_open,
    output logic [2:0]       state,
    output logic             busy,
    output logic             held,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [2:0]       rinse_idx
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_WASH  = 3'd2;
    localparam logic [2:0] ST_RINSE = 3'd3;
    localparam logic [2:0] ST_SPIN  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] MODE_QUICK = 2'b01;
    localparam logic [1:0] MODE_HEAVY = 2'b10;

    // Phase lengths as they fit in the counter width.
    localparam logic [CNT_W-1:0] FILL_LEN   = CNT_W'(T_FILL);
    localparam logic [CNT_W-1:0] WASH_LEN   = CNT_W'(T_WASH);
    localparam logic [CNT_W-1:0] WASH_QUICK = WASH_LEN >> 1;
    localparam logic [CNT_W-1:0] RINSE_LEN  = CNT_W'(T_RINSE);
    localparam logic [CNT_W-1:0] SPIN_LEN   = CNT_W'(T_SPIN);

    // Rinse pass counts, kept inside the 1..7 range a 3-bit index can address.
    localparam int N_NORM  = (N_RINSE < 1) ? 1 : ((N_RINSE > 7) ? 7 : N_RINSE);
    localparam int N_HEAVY = (N_NORM + 1 > 7) ? 7 : (N_NORM + 1);
    localparam logic [2:0] LAST_NORM  = 3'(N_NORM - 1);
    localparam logic [2:0] LAST_HEAVY = 3'(N_HEAVY - 1);

    // Counter load value for a phase length; a zero length runs as one cycle.
    function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] load;
        if (len == '0) begin
            load = '0;
        end else begin
            load = len - CNT_W'(1);
        end
        return load;
    endfunction

    // Counter load value on entry to a given phase under a given latched mode.
    function automatic logic [CNT_W-1:0] phase_load(input logic [2:0] st,
                                                    input logic [1:0] md);
        logic [CNT_W-1:0] load;
        case (st)
            ST_FILL:  load = len_to_load(FILL_LEN);
            ST_WASH:  load = (md == MODE_QUICK) ? len_to_load(WASH_QUICK)
                                                : len_to_load(WASH_LEN);
            ST_RINSE: load = len_to_load(RINSE_LEN);
            ST_SPIN:  load = len_to_load(SPIN_LEN);
            default:  load = '0;
        endcase
        return load;
    endfunction

    // Index of the final rinse pass for a latched mode (mode 11 runs as normal).
    function automatic logic [2:0] rinse_last(input logic [1:0] md);
        logic [2:0] last;
        case (md)
            MODE_QUICK: last = 3'd0;
            MODE_HEAVY: last = LAST_HEAVY;
            default:    last = LAST_NORM;
        endcase
        return last;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] remaining_s;
    logic [2:0]       rinse_idx_r;
    logic [2:0]       rinse_idx_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             held_s;
    logic             adv_s;
    logic             start_ok_s;
    logic             reload_s;

    // Hold, phase-advance and start qualifiers derived from the current state.
    always_comb begin
        held_s     = busy_r & (pause | door_open);
        adv_s      = busy_r & ~held_s & (remaining_r == '0);
        start_ok_s = (state_r == ST_IDLE) & start & ~door_open;
    end

    // State and datapath registers; reset forces an idle, cleared machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'b00;
            remaining_r <= '0;
            rinse_idx_r <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            remaining_r <= remaining_s;
            rinse_idx_r <= rinse_idx_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Next-state selection: advance only when a phase's counter expires unheld.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (adv_s) begin
                    state_s = ST_WASH;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_WASH: begin
                if (adv_s) begin
                    state_s = ST_RINSE;
                end else begin
                    state_s = ST_WASH;
                end
            end
            ST_RINSE: begin
                if (adv_s && (rinse_idx_r >= rinse_last(mode_r))) begin
                    state_s = ST_SPIN;
                end else begin
                    state_s = ST_RINSE;
                end
            end
            ST_SPIN: begin
                if (adv_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SPIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counter and rinse pass index.
    always_comb begin
        if (start_ok_s) begin
            mode_s = mode;
        end else begin
            mode_s = mode_r;
        end

        case (state_s)
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: busy_s = 1'b1;
            default:                             busy_s = 1'b0;
        endcase
        done_s = (state_s == ST_DONE);

        // A phase change, or a boundary between two rinse passes, reloads the counter.
        reload_s = (state_s != state_r) | ((state_r == ST_RINSE) & adv_s);

        if (!busy_s) begin
            remaining_s = '0;
        end else if (reload_s) begin
            remaining_s = phase_load(state_s, mode_s);
        end else if (held_s) begin
            remaining_s = remaining_r;
        end else if (remaining_r != '0) begin
            remaining_s = remaining_r - CNT_W'(1);
        end else begin
            remaining_s = remaining_r;
        end

        if (state_s != ST_RINSE) begin
            rinse_idx_s = 3'd0;
        end else if (state_r != ST_RINSE) begin
            rinse_idx_s = 3'd0;
        end else if (adv_s) begin
            rinse_idx_s = rinse_idx_r + 3'd1;
        end else begin
            rinse_idx_s = rinse_idx_r;
        end
    end

    assign state     = state_r;
    assign busy      = busy_r;
    assign held      = held_s;
    assign done      = done_r;
    assign remaining = remaining_r;
    assign rinse_idx = rinse_idx_r;

endmodule
